adaptive_fir_nlms: RTL
======================

Name: adaptive_fir_nlms

Overview:
Parametrised, time-multiplexed adaptive FIR filter with on-chip delay line, weight memory and power-of-two-normalised LMS weight update. It accepts one (x, d) sample pair per handshake, computes y = sum(w[k]*x[k]) one tap per cycle, forms e = d - y, and optionally adapts all weights before presenting the result. It is the next-generation filter core for the 16-order noise-cancellation datapath: signed arithmetic, configurable order and widths, and valid/ready handshakes on both sides.

Parameters:
TAPS, 16, filter order; number of taps, ≥2.
DW, 14, signed sample width of x, d, y, e.
WW, 32, signed weight width; weights are Q(WW-FRAC).FRAC.
FRAC, 5, fractional bits of the weights.
MU_SHIFT, 4, step size mu = 2^-MU_SHIFT.

Ports:
clk  in  1  clock, all state on rising edge.
rstn  in  1  asynchronous active-low reset.
flush  in  1  synchronous: abort the current operation, zero the delay line, keep the weights.
adapt_en  in  1  sampled at handshake; 1 = run the weight update for this sample.
in_valid  in  1  x_in/d_in valid.
in_ready  out  1  high only in IDLE.
x_in  in  DW  signed reference sample.
d_in  in  DW  signed desired sample.
out_valid  out  1  y_out/e_out valid; held until accepted.
out_ready  in  1  consumer accepts.
y_out  out  DW  signed filter output, saturated.
e_out  out  DW  signed error, saturated.
coef_we  in  1  weight write strobe; honoured only in IDLE.
coef_addr  in  clog2(TAPS)  weight index.
coef_wdata  in  WW  weight write data.
coef_rdata  out  WW  combinational read of w[coef_addr].

Behaviour:
- Reset: y_out, e_out, all weights, delay line, accumulators = 0; out_valid = 0; in_ready = 1; state = IDLE.
- State machine: IDLE -> MAC -> ERR -> (UPD if the latched adapt_en = 1) -> OUT -> IDLE.
- IDLE: on in_valid & in_ready, shift the delay line (x[k] <= x[k-1], x[0] <= x_in), latch d_in and adapt_en, clear acc/energy, set tap index i = 0, go to MAC.
- MAC: one tap per cycle, i = 0..TAPS-1. acc += w[i]*x[i] (signed, width DW+WW+clog2(TAPS), no overflow possible). energy += x[i]^2 (unsigned, width 2*DW+clog2(TAPS)). After i = TAPS-1, go to ERR.
- ERR, one cycle:
  - y = acc >>> FRAC, saturated to the signed DW range.
  - e = d - y computed at DW+1 bits, saturated to DW.
  - Register y_out and e_out.
  - nshift = index of the MSB set in energy; 0 if energy = 0.
- UPD: one tap per cycle, i = 0..TAPS-1.
  - delta = ((e*x[i]) <<< FRAC) >>> (MU_SHIFT + nshift), arithmetic shift (floor).
  - w[i] <= w[i] + delta, saturated to the signed WW range.
  - After the last tap, go to OUT.
- OUT: out_valid = 1. y_out/e_out hold stable until out_ready = 1; on that edge out_valid drops and the state returns to IDLE.
- Latency, with handshake on edge 0: out_valid rises after edge TAPS+1 (adapt off) or edge 2*TAPS+1 (adapt on).
- in_ready = (state == IDLE). in_valid outside IDLE is ignored; the sample is not lost because the producer must hold it.
- coef_we outside IDLE is ignored. coef_rdata always reflects the current weights, including mid-UPD values.
- flush, any state:
  - Next state IDLE, out_valid = 0, delay line and accumulators zeroed.
  - y_out/e_out and weights are kept.
  - flush has priority over a simultaneous handshake and over coef_we.
- Asynchronous rstn mid-operation returns the block to full reset values immediately.
- Simultaneous out_ready and in_valid in OUT: only the output is consumed; the input is accepted on the next cycle (IDLE).

Test Plan:
- Reset, weights 0, adapt_en = 0, x_in = 100, d_in = 50 -> out_valid after edge 17, y_out = 0, e_out = 50; all weights remain 0.
- Write w[0] = 32 (1.0), adapt off, x_in = 1000, d_in = 1000 -> y_out = 1000, e_out = 0; coef_rdata at addr 0 = 32.
- Saturation: w[0] = 128 (4.0), x_in = 4000, d_in = -8192 -> y_out = 8191, e_out = -8192.
- Adaptation: empty delay line, weights 0, adapt_en = 1, x_in = 1024, d_in = 512 -> energy 2^20, nshift 20, w[0] becomes 1, w[1..15] stay 0. out_valid after edge 33, e_out = 512.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_valid, y_out, e_out stable; in_ready = 0; an in_valid pulse and a coef_we in that window have no effect.
- flush asserted at MAC tap 7 -> IDLE next cycle, out_valid stays 0, delay line reads 0. The next sample x_in = 10 with w[0] = 32 and adapt off yields y_out = 10.

Source files
------------

// File: rtl/adaptive_fir_nlms.sv
// Time-multiplexed adaptive FIR filter: one tap per cycle MAC, saturated output/error,
// and an LMS weight update whose step is normalised by the power of two of the input energy.
module adaptive_fir_nlms #(
    parameter int TAPS     = 16,
    parameter int DW       = 14,
    parameter int WW       = 32,
    parameter int FRAC     = 5,
    parameter int MU_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_flush,
    input  logic                    i_adapt_en,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [DW-1:0]           i_x_in,
    input  logic [DW-1:0]           i_d_in,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DW-1:0]           o_y_out,
    output logic [DW-1:0]           o_e_out,
    input  logic                    i_coef_we,
    input  logic [$clog2(TAPS)-1:0] i_coef_addr,
    input  logic [WW-1:0]           i_coef_wdata,
    output logic [WW-1:0]           o_coef_rdata
);

    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = DW + WW + AW;
    localparam int ENW  = 2 * DW + AW;
    localparam int NSW  = $clog2(ENW);
    localparam int PW   = 2 * DW + FRAC;
    localparam int SHW  = $clog2(MU_SHIFT + ENW) + 1;
    localparam int SW   = ((WW > PW) ? WW : PW) + 1;

    localparam logic [AW-1:0]        LAST  = AW'(TAPS - 1);
    localparam logic [AW:0]          NTAPS = (AW + 1)'(TAPS);
    localparam logic signed [DW-1:0] DMAX  = {1'b0, {(DW - 1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN  = {1'b1, {(DW - 1){1'b0}}};
    localparam logic signed [WW-1:0] WMAX  = {1'b0, {(WW - 1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN  = {1'b1, {(WW - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_ERR,
        S_UPD,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DW-1:0]   r_x [TAPS];
    logic signed [WW-1:0]   r_w [TAPS];
    logic signed [ACCW-1:0] r_acc;
    logic [ENW-1:0]         r_energy;
    logic signed [DW-1:0]   r_d;
    logic signed [DW-1:0]   r_y;
    logic signed [DW-1:0]   r_e;
    logic                   r_adapt;
    logic [AW-1:0]          r_idx;
    logic [NSW-1:0]         r_nshift;

    logic                   w_addr_ok;
    logic                   w_last;
    logic signed [DW+WW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prodx;
    logic signed [2*DW-1:0] w_sq;
    logic [ENW-1:0]         w_sqx;
    logic signed [ACCW-1:0] w_yfull;
    logic signed [DW-1:0]   w_ysat;
    logic signed [DW:0]     w_ediff;
    logic signed [DW-1:0]   w_esat;
    logic [NSW-1:0]         w_nshift;
    logic signed [2*DW-1:0] w_ex;
    logic signed [PW-1:0]   w_exw;
    logic signed [PW-1:0]   w_exl;
    logic [SHW-1:0]         w_shamt;
    logic signed [PW-1:0]   w_delta;
    logic signed [SW-1:0]   w_wi;
    logic signed [SW-1:0]   w_di;
    logic signed [SW-1:0]   w_wsum;
    logic signed [WW-1:0]   w_wnew;

    assign w_addr_ok    = {1'b0, i_coef_addr} < NTAPS;
    assign w_last       = (r_idx == LAST);
    assign o_coef_rdata = w_addr_ok ? r_w[i_coef_addr] : '0;
    assign o_y_out      = r_y;
    assign o_e_out      = r_e;

    // MAC datapath: products sign-extended into accumulators wide enough to never overflow
    assign w_prod  = r_w[r_idx] * r_x[r_idx];
    assign w_prodx = w_prod;
    assign w_sq    = r_x[r_idx] * r_x[r_idx];
    assign w_sqx   = {{AW{1'b0}}, w_sq};

    assign w_yfull = r_acc >>> FRAC;
    assign w_ediff = {r_d[DW-1], r_d} - {w_ysat[DW-1], w_ysat};

    always_comb begin
        if ((&w_yfull[ACCW-1:DW-1]) || !(|w_yfull[ACCW-1:DW-1])) begin
            w_ysat = w_yfull[DW-1:0];
        end else begin
            w_ysat = w_yfull[ACCW-1] ? DMIN : DMAX;
        end
        if (w_ediff[DW] == w_ediff[DW-1]) begin
            w_esat = w_ediff[DW-1:0];
        end else begin
            w_esat = w_ediff[DW] ? DMIN : DMAX;
        end
    end

    // Position of the leading one of the energy sets the normalisation shift
    always_comb begin
        w_nshift = '0;
        for (int k = 0; k < ENW; k++) begin
            if (r_energy[k]) begin
                w_nshift = NSW'(k);
            end
        end
    end

    assign w_ex    = r_e * r_x[r_idx];
    assign w_exw   = w_ex;
    assign w_exl   = w_exw <<< FRAC;
    assign w_shamt = SHW'(MU_SHIFT) + SHW'(r_nshift);
    assign w_delta = w_exl >>> w_shamt;
    assign w_wi    = r_w[r_idx];
    assign w_di    = w_delta;
    assign w_wsum  = w_wi + w_di;

    always_comb begin
        if ((&w_wsum[SW-1:WW-1]) || !(|w_wsum[SW-1:WW-1])) begin
            w_wnew = w_wsum[WW-1:0];
        end else begin
            w_wnew = w_wsum[SW-1] ? WMIN : WMAX;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_in_valid) w_next = S_MAC;
                S_MAC:   if (w_last) w_next = S_ERR;
                S_ERR:   w_next = r_adapt ? S_UPD : S_OUT;
                S_UPD:   if (w_last) w_next = S_OUT;
                S_OUT:   if (i_out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_OUT);
    end

    // Flush clears the sample history but deliberately keeps the learned weights and last result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_w[k] <= '0;
            end
            r_acc    <= '0;
            r_energy <= '0;
            r_d      <= '0;
            r_y      <= '0;
            r_e      <= '0;
            r_adapt  <= 1'b0;
            r_idx    <= '0;
            r_nshift <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc    <= '0;
            r_energy <= '0;
            r_idx    <= '0;
        end else begin
            if (i_coef_we && w_addr_ok && (r_state == S_IDLE)) begin
                r_w[i_coef_addr] <= i_coef_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0]   <= i_x_in;
                        r_d      <= i_d_in;
                        r_adapt  <= i_adapt_en;
                        r_acc    <= '0;
                        r_energy <= '0;
                        r_idx    <= '0;
                    end
                end
                S_MAC: begin
                    r_acc    <= r_acc + w_prodx;
                    r_energy <= r_energy + w_sqx;
                    r_idx    <= w_last ? '0 : r_idx + AW'(1);
                end
                S_ERR: begin
                    r_y      <= w_ysat;
                    r_e      <= w_esat;
                    r_nshift <= w_nshift;
                end
                S_UPD: begin
                    r_w[r_idx] <= w_wnew;
                    r_idx      <= w_last ? '0 : r_idx + AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
